// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: PLL lock/reset handshake between the supervisor and top-level control
interface pll_lock_supervisor_if #(parameter int RETRY_W = 4);
  logic locked;
  logic pll_rst_out;
  logic lock_ok;
  logic lost_lock;
  logic fail;
  logic [RETRY_W-1:0] retry_cnt;
  modport master (input locked, output pll_rst_out, lock_ok, lost_lock, fail, retry_cnt);
  modport slave (output locked, input pll_rst_out, lock_ok, lost_lock, fail, retry_cnt);
endinterface

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: pulses the PLL reset, qualifies lock stability and retries on timeout or loss
module pll_lock_supervisor #(
  parameter int SYNC_STAGES = 2,
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int STABLE_CYCLES = 16,
  parameter int MAX_RETRIES = 3,
  parameter int CNT_W = 16,
  parameter int RETRY_W = 4
) (
  input logic pclk,
  input logic rst,
  pll_lock_supervisor_if.master bus
);
  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic lk_s;
  logic [CNT_W-1:0] rst_timer, acq_timer, stable_timer;
  logic [CNT_W-1:0] rst_timer_nx, acq_timer_nx, stable_timer_nx;
  logic [RETRY_W-1:0] retry, retry_nx;
  logic pll_rst_q, lock_ok_q, lost_q, fail_q;
  logic lost_nx, retry_path, timeout, stable_done, give_up;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
  assign lk_s = sync[SYNC_STAGES-1];
  // both tests look one increment ahead so the transition lands on the edge the count is reached
  assign timeout = acq_timer >= CNT_W'(LOCK_TIMEOUT - 1);
  assign stable_done = stable_timer >= CNT_W'(STABLE_CYCLES - 1);
  assign give_up = retry >= RETRY_W'(MAX_RETRIES);
  always_comb begin
    state_nx = state;
    rst_timer_nx = '0;
    acq_timer_nx = acq_timer;
    stable_timer_nx = stable_timer;
    retry_nx = retry;
    lost_nx = 1'b0;
    retry_path = 1'b0;
    case (state)
      RESET_PLL: begin
        acq_timer_nx = '0;
        stable_timer_nx = '0;
        rst_timer_nx = (rst_timer >= CNT_W'(PLL_RST_CYCLES - 1)) ? '0 : sat_inc(rst_timer);
        state_nx = (rst_timer >= CNT_W'(PLL_RST_CYCLES - 1)) ? WAIT_LOCK : RESET_PLL;
      end
      WAIT_LOCK: begin
        acq_timer_nx = sat_inc(acq_timer);
        stable_timer_nx = '0;
        if (lk_s && STABLE_CYCLES <= 1) state_nx = RUN;
        else if (timeout) retry_path = 1'b1;
        else if (lk_s) begin
          state_nx = STABLE;
          stable_timer_nx = CNT_W'(1);
        end
      end
      STABLE: begin
        acq_timer_nx = sat_inc(acq_timer);
        if (lk_s && stable_done) state_nx = RUN;
        else if (timeout) retry_path = 1'b1;
        else if (lk_s) stable_timer_nx = sat_inc(stable_timer);
        else begin
          state_nx = WAIT_LOCK;
          stable_timer_nx = '0;
        end
      end
      RUN: begin
        lost_nx = !lk_s;
        retry_path = !lk_s;
      end
      default: ;
    endcase
    state_nx = retry_path ? (give_up ? FAIL : RESET_PLL) : state_nx;
    retry_nx = (retry_path && !give_up) ? retry + 1'b1 : retry_nx;
    retry_nx = (state_nx == RUN) ? '0 : retry_nx;
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= RESET_PLL;
      sync <= '0;
      rst_timer <= '0;
      acq_timer <= '0;
      stable_timer <= '0;
      retry <= '0;
      pll_rst_q <= 1'b1;
      lock_ok_q <= 1'b0;
      lost_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      state <= state_nx;
      sync <= {sync[SYNC_STAGES-2:0], bus.locked};
      rst_timer <= rst_timer_nx;
      acq_timer <= acq_timer_nx;
      stable_timer <= stable_timer_nx;
      retry <= retry_nx;
      pll_rst_q <= state_nx == RESET_PLL || state_nx == FAIL;
      lock_ok_q <= state_nx == RUN;
      lost_q <= lost_nx;
      fail_q <= state_nx == FAIL;
    end
  end
  assign bus.pll_rst_out = pll_rst_q;
  assign bus.lock_ok = lock_ok_q;
  assign bus.lost_lock = lost_q;
  assign bus.fail = fail_q;
  assign bus.retry_cnt = retry;
  a_retry_bound: assert property (@(posedge pclk) disable iff (rst) retry <= RETRY_W'(MAX_RETRIES));
  a_ok_not_rst: assert property (@(posedge pclk) disable iff (rst) lock_ok_q |-> !pll_rst_q);
  a_fail_holds_rst: assert property (@(posedge pclk) disable iff (rst) fail_q |-> pll_rst_q && !lock_ok_q);
  a_lost_single: assert property (@(posedge pclk) disable iff (rst) lost_q |=> !lost_q);
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed lock/timeout/loss/reset scenarios with hand-computed cycle counts
module tb_pll_lock_supervisor;
  logic pclk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int n, lp;
  pll_lock_supervisor_if #(.RETRY_W(4)) bus ();
  pll_lock_supervisor #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(5),
    .MAX_RETRIES(2), .CNT_W(16), .RETRY_W(4)
  ) dut (.pclk(pclk), .rst(rst), .bus(bus));
  always #5 pclk = ~pclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // {pll_rst_out, lock_ok, lost_lock, fail, retry_cnt}
  function automatic logic [7:0] outs();
    return {bus.pll_rst_out, bus.lock_ok, bus.lost_lock, bus.fail, bus.retry_cnt};
  endfunction
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge pclk);
      #1;
    end
  endtask
  task automatic start();
    rst = 1'b1;
    bus.locked = 1'b0;
    tick(3);
    check("reset_outs", outs(), 8'h80);
    rst = 1'b0;
  endtask
  task automatic run_len(input logic lvl, output int c);
    c = 0;
    while (bus.pll_rst_out === lvl && c < 500) begin
      c++;
      tick(1);
    end
  endtask
  task automatic until_lock(output int c);
    c = 0;
    while (bus.lock_ok !== 1'b1 && c < 500) begin
      c++;
      tick(1);
    end
  endtask
  initial begin
    bus.locked = 1'b0;
    // clean lock: locked rises 2 cycles after pll_rst_out falls
    start();
    run_len(1'b1, n);
    check("clean_rst_pulse", n, 4);
    tick(2);
    bus.locked = 1'b1;
    until_lock(n);
    check("clean_lock_lat", n, 7);
    check("clean_run_outs", outs(), 8'h40);
    // one-cycle lock drop while in RUN
    tick(2);
    bus.locked = 1'b0;
    tick(1);
    bus.locked = 1'b1;
    tick(1);
    check("loss_sync_delay", outs(), 8'h40);
    tick(1);
    check("loss_detect", outs(), 8'hA1);
    n = 0;
    lp = 0;
    while (bus.pll_rst_out && n < 500) begin
      lp += int'(bus.lost_lock);
      n++;
      tick(1);
    end
    check("loss_pulse", n, 4);
    check("lost_once", lp, 1);
    check("loss_retry", bus.retry_cnt, 1);
    until_lock(n);
    check("relock_lat", n, 5);
    check("relock_outs", outs(), 8'h40);
    // glitchy acquisition: high 3, low 1, high
    start();
    run_len(1'b1, n);
    tick(2);
    bus.locked = 1'b1;
    tick(3);
    bus.locked = 1'b0;
    tick(1);
    bus.locked = 1'b1;
    until_lock(n);
    check("glitch_lock_lat", n, 7);
    check("glitch_outs", outs(), 8'h40);
    // no lock at all: three windows then FAIL
    start();
    run_len(1'b1, n);
    check("to_pulse1", n, 4);
    run_len(1'b0, n);
    check("to_window1", n, 20);
    check("to_retry1", bus.retry_cnt, 1);
    run_len(1'b1, n);
    check("to_pulse2", n, 4);
    run_len(1'b0, n);
    check("to_window2", n, 20);
    check("to_retry2", bus.retry_cnt, 2);
    run_len(1'b1, n);
    check("to_pulse3", n, 4);
    run_len(1'b0, n);
    check("to_window3", n, 20);
    check("fail_outs", outs(), 8'h92);
    bus.locked = 1'b1;
    tick(10);
    check("fail_sticky", outs(), 8'h92);
    rst = 1'b1;
    tick(1);
    check("rst_in_fail", outs(), 8'h80);
    rst = 1'b0;
    run_len(1'b1, n);
    check("after_fail_pulse", n, 4);
    // reset during the second PLL reset pulse
    start();
    run_len(1'b1, n);
    run_len(1'b0, n);
    tick(1);
    check("mid_pulse_outs", outs(), 8'h81);
    rst = 1'b1;
    tick(1);
    check("rst_mid_pulse", outs(), 8'h80);
    rst = 1'b0;
    run_len(1'b1, n);
    check("fresh_pulse", n, 4);
    check("fresh_retry", bus.retry_cnt, 0);
    // STABLE completes on the timeout edge: RUN wins
    start();
    run_len(1'b1, n);
    tick(13);
    bus.locked = 1'b1;
    until_lock(n);
    check("boundary_lat", n, 7);
    check("boundary_outs", outs(), 8'h40);
    // one cycle later: timeout beats qualification
    start();
    run_len(1'b1, n);
    tick(14);
    bus.locked = 1'b1;
    tick(6);
    check("late_timeout", outs(), 8'h81);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
